// File: rtl/fpalu_sub_iter_pkg.sv
// Shared FP ALU definitions: field widths, FSM states, unpacked operand layout.
// No logic of its own; latency not applicable.
// No handshake of its own; backpressure not applicable.
package fpalu_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int SIG_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Quiet NaN returned whenever an operand is NaN or Inf.
  localparam logic [FP_W-1:0] NAN_OUT_DEFAULT = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  // Sign, biased exponent and significand with the hidden bit restored.
  typedef struct packed {
    logic             neg;
    logic [EXP_W-1:0] exp;
    logic [SIG_W:0]   sig;
  } operand_t;

endpackage

// File: rtl/fpalu_sub_iter_if.sv
// Operand/result handshake bundle between a producer/consumer and the FP subtractor.
// Wires only; adds no latency.
// valid/ready on both the operand side and the result side.
interface fpalu_sub_iter_if;
  import fpalu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] a_input;
  logic [FP_W-1:0] b_input;
  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] diff;
  logic            ovf;
  logic            unf;
  logic            nan;

  // Producer/consumer side (drives operands, takes results).
  modport master (
    output in_valid, a_input, b_input, out_ready,
    input  in_ready, out_valid, diff, ovf, unf, nan
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, a_input, b_input, out_ready,
    output in_ready, out_valid, diff, ovf, unf, nan
  );

endinterface

// File: rtl/fpalu_sub_iter_unpack.sv
// Unpacks two operands (b negated), orders them by magnitude and computes the alignment shift.
// Purely combinational, zero latency.
// No handshake; the caller samples the outputs when it accepts.
module fpalu_unpack
  import fpalu_pkg::*;
(
  input  logic [FP_W-1:0]  a_input,
  input  logic [FP_W-1:0]  b_input,
  output logic             sign_l,
  output logic [EXP_W-1:0] exp_l,
  output logic [SIG_W:0]   sig_l,
  output logic [SIG_W:0]   sig_s,
  output logic [4:0]       cnt,
  output logic             eff_sub,
  output logic             is_nan
);

  operand_t         op_a;
  operand_t         op_b;
  logic             swap;
  logic [EXP_W-1:0] exp_s;
  logic [EXP_W-1:0] exp_gap;

  // Unpack with denormal flush, pick the larger magnitude as L, clamp the shift at 25.
  always_comb begin
    op_a.neg = a_input[FP_W-1];
    op_a.exp = a_input[FP_W-2:SIG_W];
    op_a.sig = (op_a.exp == '0) ? '0 : {1'b1, a_input[SIG_W-1:0]};
    op_b.neg = ~b_input[FP_W-1];
    op_b.exp = b_input[FP_W-2:SIG_W];
    op_b.sig = (op_b.exp == '0) ? '0 : {1'b1, b_input[SIG_W-1:0]};

    swap    = {op_b.exp, op_b.sig} > {op_a.exp, op_a.sig};
    sign_l  = swap ? op_b.neg : op_a.neg;
    exp_l   = swap ? op_b.exp : op_a.exp;
    exp_s   = swap ? op_a.exp : op_b.exp;
    sig_l   = swap ? op_b.sig : op_a.sig;
    sig_s   = swap ? op_a.sig : op_b.sig;

    exp_gap = exp_l - exp_s;
    cnt     = (exp_gap > 8'd25) ? 5'd25 : exp_gap[4:0];
    eff_sub = op_a.neg ^ op_b.neg;
    is_nan  = (op_a.exp == EXP_MAX) || (op_b.exp == EXP_MAX);
  end

endmodule

// File: rtl/fpalu_sub_iter.sv
// Iterative single-precision a - b with truncation, one-bit-per-cycle align and normalise.
// Latency cnt + n + 3 edges after accept (NaN/Inf completes on the accept edge).
// Accepts only when idle; result held in DONE until out_ready, no data loss.
module fpalu_sub_iter
  import fpalu_pkg::*;
#(
  parameter logic [FP_W-1:0] NAN_OUT = NAN_OUT_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  fpalu_sub_iter_if.slave  bus
);

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SIG_W:0]   sig_l_q, sig_l_d;
  logic [SIG_W:0]   sig_s_q, sig_s_d;
  logic [SIG_W+1:0] sum_q, sum_d;
  logic [FP_W-1:0]  diff_q, diff_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             nan_q, nan_d;

  logic             u_sign_l;
  logic [EXP_W-1:0] u_exp_l;
  logic [SIG_W:0]   u_sig_l;
  logic [SIG_W:0]   u_sig_s;
  logic [4:0]       u_cnt;
  logic             u_eff_sub;
  logic             u_is_nan;

  fpalu_unpack u_unpack (
    .a_input (bus.a_input),
    .b_input (bus.b_input),
    .sign_l  (u_sign_l),
    .exp_l   (u_exp_l),
    .sig_l   (u_sig_l),
    .sig_s   (u_sig_s),
    .cnt     (u_cnt),
    .eff_sub (u_eff_sub),
    .is_nan  (u_is_nan)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.nan       = nan_q;

  // Next-state and datapath: each state performs at most one shift per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    sig_l_d = sig_l_q;
    sig_s_d = sig_s_q;
    sum_d   = sum_q;
    diff_d  = diff_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    nan_d   = nan_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          nan_d = 1'b0;
          if (u_is_nan) begin
            diff_d  = NAN_OUT;
            nan_d   = 1'b1;
            state_d = DONE;
          end else begin
            sign_d  = u_sign_l;
            exp_d   = u_exp_l;
            sig_l_d = u_sig_l;
            sig_s_d = u_sig_s;
            cnt_d   = u_cnt;
            sub_d   = u_eff_sub;
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (cnt_q != 5'd0) begin
          sig_s_d = sig_s_q >> 1;
          cnt_d   = cnt_q - 5'd1;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        // L has the larger magnitude, so the difference can never go negative.
        sum_d   = sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                        : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
        state_d = NORM;
      end
      NORM: begin
        if (sum_q == '0) begin
          diff_d  = '0;
          state_d = DONE;
        end else if (sum_q[SIG_W+1]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_q + 8'd1;
          if (exp_q == EXP_MAX - 8'd1) begin
            diff_d  = {sign_q, EXP_MAX, {SIG_W{1'b0}}};
            ovf_d   = 1'b1;
            state_d = DONE;
          end
        end else if (!sum_q[SIG_W]) begin
          if (exp_q == 8'd1) begin
            diff_d  = '0;
            unf_d   = 1'b1;
            state_d = DONE;
          end else begin
            sum_d = {sum_q[SIG_W:0], 1'b0};
            exp_d = exp_q - 8'd1;
          end
        end else begin
          diff_d  = {sign_q, exp_q, sum_q[SIG_W-1:0]};
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      sig_l_q <= '0;
      sig_s_q <= '0;
      sum_q   <= '0;
      diff_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      sig_l_q <= sig_l_d;
      sig_s_q <= sig_s_d;
      sum_q   <= sum_d;
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      nan_q   <= nan_d;
    end
  end

endmodule

// File: tb/tb_fpalu_sub_iter.sv
// Directed and randomised checks of the iterative FP subtractor against an arithmetic model.
// Latency measured in rising edges after the accept edge.
// Exercises held results with out_ready low and ignored in_valid while busy.
module tb_fpalu_sub_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fpalu_sub_iter_if bus ();

  fpalu_sub_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_diff;
  logic [2:0]  exp_flags;
  int          exp_lat;
  bit          track = 1'b0;
  bit          seen = 1'b0;
  int          edges = 0;

  // Arithmetic model: flags are {ovf, unf, nan}; lat counts edges after the accept edge.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic [2:0] f, output int lat);
    int     ea, eb, el, es, k, e, p, sh;
    longint ma, mb, ml, ms, sum;
    bit     sa, sb, sl, ss;
    d = 32'h0; f = 3'b000; lat = 0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      d = 32'h7FC0_0000; f = 3'b001; lat = 0;
      return;
    end
    ma = (ea == 0) ? 64'd0 : (longint'(a[22:0]) + 64'h80_0000);
    mb = (eb == 0) ? 64'd0 : (longint'(b[22:0]) + 64'h80_0000);
    sa = a[31];
    sb = !b[31];
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb;
    end else begin
      el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa;
    end
    k = el - es;
    if (k > 25) k = 25;
    ms  = ms >> k;
    sum = (sl != ss) ? (ml - ms) : (ml + ms);
    e   = el;
    if (sum == 0) begin
      d = 32'h0; lat = k + 3;
    end else if (sum >= 64'h100_0000) begin
      if (e + 1 >= 255) begin
        d = {sl, 8'hFF, 23'h0}; f = 3'b100; lat = k + 3;
      end else begin
        d = {sl, 8'(e + 1), 23'(sum >> 1)}; lat = k + 4;
      end
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (sum[i]) p = i;
      sh = 23 - p;
      if (e - sh >= 1) begin
        d = {sl, 8'(e - sh), 23'(sum << sh)}; lat = k + 3 + sh;
      end else begin
        d = 32'h0; f = 3'b010; lat = k + 3 + e - 1;
      end
    end
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // One operation: optional literal pin of the model, then the DUT is checked by the compare loop.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit lit,
                        input logic [31:0] ld, input logic [2:0] lf, input int ll, input int hold);
    logic [31:0] md;
    logic [2:0]  mf;
    int          ml;
    model(a, b, md, mf, ml);
    if (lit) begin
      check(md == ld, "model_diff", md, ld);
      check(mf == lf && ml == ll, "model_flags_lat", {mf, 29'(ml)}, {lf, 29'(ll)});
    end
    exp_diff  = md;
    exp_flags = mf;
    exp_lat   = ml;
    @(negedge clk);
    bus.a_input   = a;
    bus.b_input   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    seen  = 1'b0;
    edges = 0;
    track = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) @(negedge clk);
    if (!seen) check(1'b0, "timeout", 32'(edges), 32'(exp_lat));
    // Busy-time operands must be ignored.
    if (hold > 0) begin
      bus.a_input  = 32'h4040_0000;
      bus.b_input  = 32'h3F80_0000;
      bus.in_valid = 1'b1;
    end
    repeat (hold) @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    track         = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check(!bus.out_valid && bus.in_ready, "release",
          {30'h0, bus.out_valid, bus.in_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_input   = 32'h0;
    bus.b_input   = 32'h0;

    // Compare process: latency at first out_valid, then held result every cycle until released.
    fork
      forever begin
        @(negedge clk);
        if (track) begin
          if (bus.out_valid) begin
            if (!seen) begin
              seen = 1'b1;
              check(edges == exp_lat, "latency", 32'(edges), 32'(exp_lat));
            end
            check(bus.diff == exp_diff, "diff", bus.diff, exp_diff);
            check({bus.ovf, bus.unf, bus.nan} == exp_flags && !bus.in_ready, "flags_inrdy",
                  {28'h0, bus.ovf, bus.unf, bus.nan, bus.in_ready}, {28'h0, exp_flags, 1'b0});
          end else if (!seen) begin
            edges++;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check(bus.in_ready && !bus.out_valid, "reset_hs",
          {30'h0, bus.in_ready, bus.out_valid}, 32'h2);
    check(bus.diff == 32'h0 && {bus.ovf, bus.unf, bus.nan} == 3'b000, "reset_out",
          {bus.diff[28:0], bus.ovf, bus.unf, bus.nan}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h4040_0000, 32'h3F80_0000, 1, 32'h4000_0000, 3'b000, 4, 0);
    run_op(32'h3F80_0000, 32'h3F40_0000, 1, 32'h3E80_0000, 3'b000, 6, 0);
    run_op(32'h3F80_0000, 32'hBF80_0000, 1, 32'h4000_0000, 3'b000, 4, 0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1, 32'h0000_0000, 3'b000, 3, 0);
    run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1, 32'h7F80_0000, 3'b100, 3, 0);
    run_op(32'h0080_0001, 32'h0080_0000, 1, 32'h0000_0000, 3'b010, 3, 0);
    run_op(32'h7F80_0000, 32'h3F80_0000, 1, 32'h7FC0_0000, 3'b001, 0, 10);
    run_op(32'h3F80_0000, 32'h4040_0000, 1, 32'hC000_0000, 3'b000, 4, 0);
    run_op(32'h4B00_0000, 32'h3F80_0000, 1, 32'h4AFF_FFFE, 3'b000, 27, 0);
    run_op(32'h4C00_0000, 32'h3F80_0000, 1, 32'h4C00_0000, 3'b000, 28, 0);
    run_op(32'h4C80_0000, 32'h3F80_0000, 1, 32'h4C80_0000, 3'b000, 28, 0);
    run_op(32'h0040_0000, 32'h3F80_0000, 1, 32'hBF80_0000, 3'b000, 28, 0);
    run_op(32'h3F80_0000, 32'hFF80_0000, 1, 32'h7FC0_0000, 3'b001, 0, 2);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb[30:23] = ra[30:23] ^ {5'b0, rb[25:23]};
      run_op(ra, rb, 0, 32'h0, 3'b000, 0, i % 3);
    end

    // Reset in the middle of a 23-step alignment.
    @(negedge clk);
    bus.a_input  = 32'h4B00_0000;
    bus.b_input  = 32'h3F80_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(!bus.out_valid && bus.in_ready, "midreset_hs",
          {30'h0, bus.out_valid, bus.in_ready}, 32'h1);
    check(bus.diff == 32'h0, "midreset_diff", bus.diff, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h4040_0000, 32'h3F80_0000, 1, 32'h4000_0000, 3'b000, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
